// File: rtl/doorbell_chime_sequencer_if.sv
// Ring-request / chime-output bundle between the button debouncers, the sequencer and the sound mux.
// master = request source and output observer; slave = the sequencer.
interface doorbell_chime_sequencer_if;
  logic       front_req;
  logic       back_req;
  logic       sel;
  logic       en;
  logic       busy;
  logic       front_ack;
  logic       back_ack;
  logic [1:0] note_idx;

  modport master (
    output front_req, back_req,
    input  sel, en, busy, front_ack, back_ack, note_idx
  );

  modport slave (
    input  front_req, back_req,
    output sel, en, busy, front_ack, back_ack, note_idx
  );
endinterface

// File: rtl/doorbell_chime_sequencer.sv
// Two-door chime sequencer driving the 2:1 sound mux select and audio enable, round-robin on ties.
// Latency: req sampled at an idle edge starts the chime at that edge; no backpressure, requests are held as pending flags.
module doorbell_chime_sequencer #(
  parameter int TONE_LEN = 8,
  parameter int GAP_LEN  = 4,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  doorbell_chime_sequencer_if.slave    bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NOTE = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic DOOR_FRONT = 1'b0;
  localparam logic DOOR_BACK  = 1'b1;

  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  logic [1:0]       state;
  logic             door;
  logic             last_served;
  logic             pend_front;
  logic             pend_back;
  logic [CNT_W-1:0] cnt;

  logic       sel_q;
  logic       en_q;
  logic       busy_q;
  logic       front_ack_q;
  logic       back_ack_q;
  logic [1:0] note_idx_q;

  logic cand_front;
  logic cand_back;
  logic start;
  logic pick_back;
  logic last_note;
  logic tone_end;
  logic gap_end;
  logic front_playing;
  logic back_playing;

  always_comb begin
    cand_front    = pend_front | bus.front_req;
    cand_back     = pend_back  | bus.back_req;
    start         = (state == IDLE) && (cand_front || cand_back);
    // Back wins only if it is the sole candidate or front was served last.
    pick_back     = cand_back && (!cand_front || (last_served == DOOR_FRONT));
    last_note     = (door == DOOR_BACK) ? (note_idx_q == 2'd2) : (note_idx_q == 2'd1);
    tone_end      = (cnt == TONE_LAST);
    gap_end       = (cnt == GAP_LAST);
    front_playing = (state != IDLE) && (door == DOOR_FRONT);
    back_playing  = (state != IDLE) && (door == DOOR_BACK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      door        <= DOOR_FRONT;
      last_served <= DOOR_BACK;
      pend_front  <= 1'b0;
      pend_back   <= 1'b0;
      cnt         <= '0;
      sel_q       <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      front_ack_q <= 1'b0;
      back_ack_q  <= 1'b0;
      note_idx_q  <= 2'd0;
    end else begin
      front_ack_q <= 1'b0;
      back_ack_q  <= 1'b0;

      // A door's own request is ignored while its chime runs; the other door's is latched.
      if (start && !pick_back)
        pend_front <= 1'b0;
      else if (bus.front_req && !front_playing)
        pend_front <= 1'b1;

      if (start && pick_back)
        pend_back <= 1'b0;
      else if (bus.back_req && !back_playing)
        pend_back <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state       <= NOTE;
            door        <= pick_back;
            last_served <= pick_back;
            cnt         <= '0;
            note_idx_q  <= 2'd0;
            en_q        <= 1'b1;
            busy_q      <= 1'b1;
            sel_q       <= pick_back;
            front_ack_q <= !pick_back;
            back_ack_q  <= pick_back;
          end
        end

        NOTE: begin
          if (tone_end) begin
            cnt <= '0;
            if (last_note) begin
              state <= GAP;
              en_q  <= 1'b0;
            end else begin
              note_idx_q <= note_idx_q + 2'd1;
              // front = a,b tracks idx[0]; back = b,a,b tracks ~idx[0] of the next note.
              sel_q      <= (door == DOOR_BACK) ? note_idx_q[0] : ~note_idx_q[0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          if (gap_end) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            note_idx_q <= 2'd0;
            sel_q      <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.front_ack = front_ack_q;
  assign bus.back_ack  = back_ack_q;
  assign bus.note_idx  = note_idx_q;

endmodule

// File: tb/tb_doorbell_chime_sequencer.sv
// Directed bench for the doorbell chime sequencer: vector tables for single chimes, hand sequences for ties and resets.
module tb_doorbell_chime_sequencer;

  localparam int TL = 8;
  localparam int GL = 4;

  typedef struct {
    bit         rst_n;
    bit         front;
    bit         back;
    logic [6:0] exp;   // {sel, en, busy, front_ack, back_ack, note_idx}
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  vec_t tfront[$];
  vec_t tback[$];

  doorbell_chime_sequencer_if bus_i ();

  doorbell_chime_sequencer #(
    .TONE_LEN (TL),
    .GAP_LEN  (GL),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] outs();
    return {bus_i.sel, bus_i.en, bus_i.busy, bus_i.front_ack, bus_i.back_ack, bus_i.note_idx};
  endfunction

  // Expected outputs k edges after a chime's start edge (k=0 is the start edge).
  function automatic logic [6:0] ev(input bit back, input int k);
    int         notes;
    logic [1:0] idx;
    logic       s;
    notes = back ? 3 : 2;
    if (k < notes * TL) begin
      idx = 2'(k / TL);
      s   = back ? ~idx[0] : idx[0];
      return {s, 1'b1, 1'b1, (k == 0) && !back, (k == 0) && back, idx};
    end else if (k < notes * TL + GL) begin
      return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'(notes - 1)};
    end
    return 7'd0;
  endfunction

  task automatic step(input bit r, input bit f, input bit b, input logic [6:0] exp, input string nm);
    logic [6:0] act;
    @(negedge clk);
    rst_n           = r;
    bus_i.front_req = f;
    bus_i.back_req  = b;
    @(posedge clk);
    #1;
    act   = outs();
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got {sel,en,busy,fack,back,idx}=%b want=%b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(inout vec_t q[$], input bit f, input bit b, input logic [6:0] e, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst_n = 1'b1;
      v.front = (i == 0) ? f : 1'b0;
      v.back  = (i == 0) ? b : 1'b0;
      v.exp   = e;
      q.push_back(v);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst_n           = 1'b0;
    bus_i.front_req = 1'b0;
    bus_i.back_req  = 1'b0;

    // Single front chime: a for 8, b for 8, gap 4, then idle.
    add(tfront, 1'b1, 1'b0, 7'b0111_0_00, 1);
    add(tfront, 1'b0, 1'b0, 7'b0110_0_00, 7);
    add(tfront, 1'b0, 1'b0, 7'b1110_0_01, 8);
    add(tfront, 1'b0, 1'b0, 7'b1010_0_01, 4);
    add(tfront, 1'b0, 1'b0, 7'b0000_0_00, 3);
    // Single back chime: b, a, b for 8 each, gap 4, then idle.
    add(tback, 1'b0, 1'b1, 7'b1110_1_00, 1);
    add(tback, 1'b0, 1'b0, 7'b1110_0_00, 7);
    add(tback, 1'b0, 1'b0, 7'b0110_0_01, 8);
    add(tback, 1'b0, 1'b0, 7'b1110_0_10, 8);
    add(tback, 1'b0, 1'b0, 7'b1010_0_10, 4);
    add(tback, 1'b0, 1'b0, 7'b0000_0_00, 3);

    // Reset held with both requests high, then released with requests low.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 7'd0, "reset_hold");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 7'd0, "reset_release_no_ack");

    // First tie after reset: front wins, back starts one idle cycle after the gap.
    step(1'b1, 1'b1, 1'b1, ev(1'b0, 0), "tie1_front_start");
    for (int k = 1; k <= 2 * TL + GL; k++) step(1'b1, 1'b0, 1'b0, ev(1'b0, k), "tie1_front_body");
    for (int k = 0; k <= 3 * TL + GL; k++) step(1'b1, 1'b0, 1'b0, ev(1'b1, k), "tie1_back_body");

    foreach (tfront[i]) step(tfront[i].rst_n, tfront[i].front, tfront[i].back, tfront[i].exp, "tbl_front");

    // Front served last, so this tie goes to back.
    step(1'b1, 1'b1, 1'b1, ev(1'b1, 0), "tie2_back_start");
    for (int k = 1; k <= 3 * TL + GL; k++) step(1'b1, 1'b0, 1'b0, ev(1'b1, k), "tie2_back_body");
    for (int k = 0; k <= 2 * TL + GL; k++) step(1'b1, 1'b0, 1'b0, ev(1'b0, k), "tie2_front_body");

    foreach (tback[i]) step(tback[i].rst_n, tback[i].front, tback[i].back, tback[i].exp, "tbl_back");

    // Front re-pressed during its own chime is dropped.
    step(1'b1, 1'b1, 1'b0, ev(1'b0, 0), "rereq_start");
    for (int k = 1; k <= 2 * TL + GL; k++) step(1'b1, (k == 5), 1'b0, ev(1'b0, k), "rereq_body");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 7'd0, "rereq_stays_idle");

    // Reset mid back chime with a front request latched: all cleared, no late front chime.
    step(1'b1, 1'b0, 1'b1, ev(1'b1, 0), "midrst_back_start");
    for (int k = 1; k < 10; k++) step(1'b1, (k == 3), 1'b0, ev(1'b1, k), "midrst_back_body");
    step(1'b0, 1'b0, 1'b0, 7'd0, "midrst_abort");
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 7'd0, "midrst_pend_cleared");
    step(1'b1, 1'b1, 1'b0, ev(1'b0, 0), "postrst_front_start");
    for (int k = 1; k <= 2 * TL + GL + 1; k++) step(1'b1, 1'b0, 1'b0, ev(1'b0, k), "postrst_front_body");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/doorbell_chime_sequencer.md
Name: doorbell_chime_sequencer

Overview:
- Controller for the two-sound doorbell mux (sound a on sel=0, sound b on sel=1).
- Accepts ring requests from two buttons, front and back. Each door plays a fixed note pattern by driving the mux select and an audio enable.
- Arbitrates round-robin when both doors are pending.
- Sits between the button debouncers and the 2:1 sound mux; the mux's 5-tick output delay is outside this block.

Parameters:
- TONE_LEN, 8: clock cycles per note, minimum 1.
- GAP_LEN, 4: silent cycles after each chime before the next may start, minimum 1.
- CNT_W, 8: width of the cycle counter; must hold max(TONE_LEN, GAP_LEN)-1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous reset, active-low.
- front_req, input, 1: front-door ring request, sampled each edge.
- back_req, input, 1: back-door ring request, sampled each edge.
- sel, output, 1: mux select; 0 = sound a, 1 = sound b.
- en, output, 1: audio enable; 1 while a note plays.
- busy, output, 1: chime or gap in progress.
- front_ack, output, 1: one-cycle pulse when the front chime starts.
- back_ack, output, 1: one-cycle pulse when the back chime starts.
- note_idx, output, 2: index of the current note within the pattern.

Behaviour:
- All outputs are registered.
- Reset: rst_n=0 at an edge forces the following state. This also applies mid-chime: the chime aborts with no gap.
  - state=IDLE.
  - sel=0, en=0, busy=0, front_ack=0, back_ack=0, note_idx=0.
  - Pending flags cleared; counter=0.
  - last_served=BACK, so front wins the first tie.
- Patterns:
  - FRONT = a,b (sel 0,1; 2 notes).
  - BACK = b,a,b (sel 1,0,1; 3 notes).
- Pending flags:
  - pend_x is set at any edge where x_req=1.
  - x_req is ignored while door x's own chime is in NOTE or GAP.
  - The other door's req is latched in that case.
  - pend_x clears at the edge its chime starts.
- States:
  - IDLE: en=0, busy=0.
    - Candidate set = pend_x OR x_req, for x in {front, back}.
    - If both are candidates, serve the door != last_served.
    - If one is a candidate, serve it.
    - On start (same edge):
      - state=NOTE, note_idx=0, counter=0.
      - en=1, busy=1, sel=pattern[0].
      - x_ack=1 for exactly one cycle; last_served=x.
    - Start latency: req sampled at edge E0 gives en=1 visible after E0.
  - NOTE: en=1, busy=1.
    - counter increments each edge.
    - When counter=TONE_LEN-1 and more notes remain: note_idx+1, sel=next pattern bit, counter=0. There is no silent cycle between notes.
    - When counter=TONE_LEN-1 on the last note: state=GAP, en=0, sel holds its last value, counter=0.
  - GAP: en=0, busy=1.
    - At counter=GAP_LEN-1: state=IDLE, busy=0, note_idx=0, sel=0.
- Timing for a FRONT chime started at E0:
  - Note 0 covers E0..E0+TONE_LEN-1.
  - Note 1 follows for TONE_LEN cycles.
  - GAP follows for GAP_LEN cycles.
  - IDLE from edge E0+2*TONE_LEN+GAP_LEN.
- Pending back-to-back chimes: a request pending at IDLE entry starts at the first IDLE edge, so there is exactly 1 idle cycle (busy=0) between chimes.
- Simultaneous front_req and back_req in IDLE: one starts per the round-robin rule. The other is latched and plays after the first chime's GAP plus one IDLE cycle.
- Acks: front_ack and back_ack are never high together. Each is high only on the first NOTE cycle.
- Counter wrap: not possible, because the counter resets at its terminal counts.

Test Plan:
- Reset defaults: hold rst_n=0 for 3 edges with both reqs high -> all outputs 0; no ack after release until a new req edge.
- Single front request (TONE_LEN=8, GAP_LEN=4): front_req pulse at E0 ->
  - front_ack=1 only after E0.
  - sel=0, en=1 for E0..E0+7.
  - sel=1, en=1 for E0+8..E0+15, note_idx=1.
  - en=0, busy=1 for E0+16..E0+19.
  - busy=0 at E0+20.
- Single back request: back_req pulse at E0 -> sel sequence 1,0,1 with 8 cycles each and en=1 for 24 cycles; busy falls at E0+28.
- Simultaneous requests, then fairness:
  - front_req and back_req both high at E0 -> front plays first; back_ack at E0+21.
  - Repeat the simultaneous pulse after idle -> back plays first this time.
- Ignored re-request: front_req re-pulsed at E0+5 during the front chime -> no second front chime; busy=0 at E0+20 and stays 0.
- Mid-chime reset: rst_n=0 at E0+10 of a back chime -> after that edge en=0, busy=0, sel=0, pending flags clear; a new front_req plays normally.
